// File: rtl/fft_out_unload_if.sv
// Output stream of the FFT unload buffer: valid/ready handshake carrying one
// natural-order bin per beat plus an end-of-frame marker.
interface fft_out_unload_if #(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18
);
  logic                      ovalid;
  logic                      oready;
  logic [TOTAL_STAGE_P-1:0]  oindex;
  logic [2*MULT_WIDTH_P-1:0] odata;
  logic                      olast;

  modport master (output ovalid, oindex, odata, olast, input oready);
  modport slave  (input ovalid, oindex, odata, olast, output oready);
endinterface

// File: rtl/fft_out_unload.sv
// FFT sink: captures one N-point frame from the last FFT stage into a
// ping-pong buffer and replays it in natural bin order over valid/ready.
module fft_out_unload #(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18,
  parameter int BIT_REV       = 1
) (
  input  logic                      iclk,
  input  logic                      rst,
  input  logic                      ien,
  input  logic [TOTAL_STAGE_P-1:0]  iaddr,
  input  logic [2*MULT_WIDTH_P-1:0] idata,
  fft_out_unload_if.master          ob,
  output logic                      ooverflow
);
  localparam int N = 1 << TOTAL_STAGE_P;
  localparam int W = 2 * MULT_WIDTH_P;
  localparam logic [TOTAL_STAGE_P-1:0] LAST_IDX = '1;
  localparam logic [TOTAL_STAGE_P-1:0] PENULT_IDX = TOTAL_STAGE_P'(N - 2);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} rd_state_t;

  logic [W-1:0]             mem [0:2*N-1];
  logic [W-1:0]             ram_q;
  logic [1:0]               full;
  logic                     wr_bank;
  logic                     rd_bank;
  logic [TOTAL_STAGE_P-1:0] wr_cnt;
  logic [TOTAL_STAGE_P-1:0] waddr;
  logic                     dropping;
  logic                     frame_start;
  logic                     drop_now;
  logic                     wr_en;
  logic                     wr_done;
  logic [1:0]               full_set;
  logic [1:0]               full_clr;

  rd_state_t                state, state_nxt;
  logic                     ren;
  logic [TOTAL_STAGE_P-1:0] raddr;
  logic                     load_first;
  logic                     advance;
  logic                     rd_done;
  logic                     fire;

  // Write address: optional bit reversal is a pure wire permutation.
  always_comb begin
    waddr = iaddr;
    if (BIT_REV != 0) begin
      for (int unsigned i = 0; i < TOTAL_STAGE_P; i++) begin
        waddr[i] = iaddr[TOTAL_STAGE_P-1-i];
      end
    end
  end

  // Drop decision is made once per frame at its first sample and then held.
  always_comb begin
    frame_start = ien && (wr_cnt == '0);
    drop_now    = frame_start ? full[wr_bank] : dropping;
    wr_en       = ien && !drop_now;
    wr_done     = wr_en && (wr_cnt == LAST_IDX);
    full_set    = wr_done ? (2'b01 << wr_bank) : 2'b00;
    full_clr    = rd_done ? (2'b01 << rd_bank) : 2'b00;
  end

  // Writer bookkeeping: sample count, bank select, drop state, sticky overflow.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      dropping  <= 1'b0;
      ooverflow <= 1'b0;
    end else if (ien) begin
      wr_cnt   <= wr_cnt + 1'b1;
      dropping <= drop_now;
      if (frame_start && full[wr_bank]) ooverflow <= 1'b1;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  // Bank full flags; writer set and reader clear always hit different banks.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) full <= '0;
    else     full <= (full & ~full_clr) | full_set;
  end

  // Buffer RAM write port.
  always_ff @(posedge iclk) begin
    if (wr_en) mem[{wr_bank, waddr}] <= idata;
  end

  // Registered RAM read port; it only advances on demand so it doubles as the
  // output data register and holds steady under back-pressure.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst)      ram_q <= '0;
    else if (ren) ram_q <= mem[{rd_bank, raddr}];
  end

  assign fire     = ob.ovalid && ob.oready;
  assign ob.odata = ram_q;

  // Read FSM state register.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Read FSM next state and RAM/output control.
  always_comb begin
    state_nxt  = state;
    ren        = 1'b0;
    raddr      = ob.oindex + 1'b1;
    load_first = 1'b0;
    advance    = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          ren       = 1'b1;
          raddr     = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        load_first = 1'b1;
        state_nxt  = STREAM;
      end
      STREAM: begin
        if (fire) begin
          if (ob.oindex == LAST_IDX) begin
            rd_done   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ren     = 1'b1;
            advance = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output handshake registers and read bank select.
  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      ob.ovalid <= 1'b0;
      ob.olast  <= 1'b0;
      ob.oindex <= '0;
      rd_bank   <= 1'b0;
    end else if (load_first) begin
      ob.ovalid <= 1'b1;
      ob.oindex <= '0;
      ob.olast  <= 1'b0;
    end else if (rd_done) begin
      ob.ovalid <= 1'b0;
      ob.olast  <= 1'b0;
      rd_bank   <= ~rd_bank;
    end else if (advance) begin
      ob.oindex <= ob.oindex + 1'b1;
      ob.olast  <= (ob.oindex == PENULT_IDX);
    end
  end
endmodule

// File: tb/tb_fft_out_unload.sv
// Bench for fft_out_unload with N=8, bit-reversed input addressing.
module tb_fft_out_unload;
  localparam int P  = 3;
  localparam int MW = 8;
  localparam int N  = 1 << P;
  localparam int W  = 2 * MW;

  logic         iclk = 1'b0;
  logic         rst;
  logic         ien;
  logic [P-1:0] iaddr;
  logic [W-1:0] idata;
  logic         ooverflow;

  int n_cmp = 0;
  int n_bad = 0;

  fft_out_unload_if #(.TOTAL_STAGE_P(P), .MULT_WIDTH_P(MW)) ob ();

  fft_out_unload #(.TOTAL_STAGE_P(P), .MULT_WIDTH_P(MW), .BIT_REV(1)) dut (
    .iclk      (iclk),
    .rst       (rst),
    .ien       (ien),
    .iaddr     (iaddr),
    .idata     (idata),
    .ob        (ob),
    .ooverflow (ooverflow)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [P-1:0] brev(input logic [P-1:0] a);
    logic [P-1:0] r;
    for (int i = 0; i < P; i++) r[i] = a[P-1-i];
    return r;
  endfunction

  // Model: frames that completed capture, flattened in natural bin order.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fr [N];
  int occ = 0;
  int wcnt = 0;
  bit mdrop = 0;
  int out_idx = 0;
  int drops = 0;
  int fires = 0;
  bit hold_prev = 0;
  logic [P-1:0] prev_idx;
  logic [W-1:0] prev_data;
  logic         prev_last;

  // Sampled on the falling edge: the values seen describe the next rising edge.
  always @(negedge iclk) begin
    if (rst) begin
      exp_q.delete();
      occ = 0; wcnt = 0; mdrop = 0; out_idx = 0; hold_prev = 0;
    end else begin
      if (ob.ovalid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(ob.ovalid), 32'd0);
        end else begin
          chk("oindex", 32'(ob.oindex), 32'(out_idx));
          chk("odata", 32'(ob.odata), 32'(exp_q[0]));
          chk("olast", 32'(ob.olast), 32'(out_idx == N-1));
        end
        if (hold_prev) begin
          chk("hold_idx", 32'(ob.oindex), 32'(prev_idx));
          chk("hold_data", 32'(ob.odata), 32'(prev_data));
          chk("hold_last", 32'(ob.olast), 32'(prev_last));
        end
      end else if (hold_prev) begin
        chk("valid_withdrawn", 32'(ob.ovalid), 32'd1);
      end
      hold_prev = ob.ovalid && !ob.oready;
      prev_idx  = ob.oindex;
      prev_data = ob.odata;
      prev_last = ob.olast;

      // A frame is dropped when both banks still hold unread frames at its start.
      if (ien) begin
        if (wcnt == 0) begin
          mdrop = (occ == 2);
          if (mdrop) drops++;
        end
        if (!mdrop) fr[brev(iaddr)] = idata;
        if (wcnt == N-1 && !mdrop) begin
          for (int k = 0; k < N; k++) exp_q.push_back(fr[k]);
          occ++;
        end
        wcnt = (wcnt + 1) % N;
      end

      if (ob.ovalid && ob.oready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        fires++;
        if (out_idx == N-1) begin
          out_idx = 0;
          occ--;
        end else begin
          out_idx++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic send_words(input int fid, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      ien   = 1'b1;
      iaddr = P'(k);
      idata = {8'(fid), 8'(k)};
      tick();
    end
    ien = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit done = 0;
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && !ob.ovalid) begin
        done = 1;
        break;
      end
      tick();
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] lit [N];
    int d0, f0;
    bit found;
    lit = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
    rst = 1'b1; ien = 1'b0; iaddr = '0; idata = '0; ob.oready = 1'b0;
    #1;
    chk("rst_ovalid", 32'(ob.ovalid), 32'd0);
    chk("rst_olast", 32'(ob.olast), 32'd0);
    chk("rst_oindex", 32'(ob.oindex), 32'd0);
    chk("rst_odata", 32'(ob.odata), 32'd0);
    chk("rst_ooverflow", 32'(ooverflow), 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Single frame, idata = iaddr; latency and literal bit-reversed order.
    ob.oready = 1'b1;
    send_words(0, N);
    chk("lat_e0", 32'(ob.ovalid), 32'd0);
    tick();
    chk("lat_e1", 32'(ob.ovalid), 32'd0);
    tick();
    chk("lat_e2_valid", 32'(ob.ovalid), 32'd1);
    chk("lat_e2_index", 32'(ob.oindex), 32'd0);
    for (int j = 0; j < N; j++) begin
      @(negedge iclk);
      chk("t1_valid", 32'(ob.ovalid), 32'd1);
      chk("t1_data", 32'(ob.odata), 32'(lit[j]));
      chk("t1_index", 32'(ob.oindex), 32'(j));
      chk("t1_last", 32'(ob.olast), 32'(j == N-1));
      tick();
    end
    chk("t1_valid_after_last", 32'(ob.ovalid), 32'd0);

    // Random back-pressure over two frames.
    f0 = fires;
    fork
      begin send_words(10, N); send_words(11, N); end
      begin
        repeat (60) begin
          ob.oready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    ob.oready = 1'b1;
    drain("t3_drain");
    chk("t3_count", 32'(fires - f0), 32'(2*N));

    // Overflow: three frames while stalled, third is dropped.
    ob.oready = 1'b0;
    d0 = drops; f0 = fires;
    send_words(20, N); send_words(21, N); send_words(22, N);
    tick(); tick(); tick();
    chk("t4_overflow", 32'(ooverflow), 32'd1);
    chk("t4_model_drops", 32'(drops - d0), 32'd1);
    ob.oready = 1'b1;
    drain("t4_drain");
    chk("t4_count", 32'(fires - f0), 32'(2*N));
    chk("t4_overflow_sticky", 32'(ooverflow), 32'd1);

    // Four frames with the reader running freely: none lost.
    d0 = drops; f0 = fires;
    for (int f = 0; f < 4; f++) begin
      send_words(30 + f, N);
      tick(); tick();
    end
    drain("t5_drain");
    chk("t5_count", 32'(fires - f0), 32'(4*N));
    chk("t5_drops", 32'(drops - d0), 32'd0);
    chk("t5_overflow", 32'(ooverflow), 32'd1);

    // Reset mid-write.
    send_words(40, 4);
    rst = 1'b1;
    #1;
    chk("t6w_ovalid", 32'(ob.ovalid), 32'd0);
    chk("t6w_ooverflow", 32'(ooverflow), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    chk("t6w_no_output", 32'(ob.ovalid), 32'd0);

    // Reset mid-read.
    send_words(41, N);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (ob.ovalid && ob.oindex == 3'd3) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("t6r_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6r_ovalid", 32'(ob.ovalid), 32'd0);
    chk("t6r_oindex", 32'(ob.oindex), 32'd0);
    chk("t6r_olast", 32'(ob.olast), 32'd0);
    tick();
    rst = 1'b0;
    f0 = fires;
    send_words(42, N);
    drain("t6_drain");
    chk("t6_count", 32'(fires - f0), 32'(N));
    chk("t6_overflow", 32'(ooverflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
